cfe_trigger_scheduler: RTL and testbench
========================================

// Module: cfe_trigger_scheduler
// PURPOSE
//  Consumes the feedback wait time from the CFE wait-feedback stage and schedules CFE estimation runs.
//  Counts down the wait time, then fires a one-cycle start pulse to the CFE.
//  Then waits for the CFE valid, or times out, and reloads the new wait.
//  The reload happens one cycle after the valid, because the feedback stage updates its wait on the valid edge.
// PARAMETERS
//  CFE_NBW_LAT   'd32    width of i_wait and o_wait_remaining (cycles)
//  CFE_NBW_TMO   'd16    width of the timeout counter
//  CFE_TIMEOUT   'd1024  cycles allowed in BUSY for i_cfe_valid before timeout (>=1)
//  CFE_NBW_CNT   'd16    width of the o_n_starts event counter
// PORTS
//  clk               in   1            clock
//  rst_async         in   1            reset, asynchronous, active-high
//  i_enable          in   1            scheduler enable (level)
//  i_wait            in   CFE_NBW_LAT  wait time from feedback stage, cycles
//  i_cfe_valid       in   1            CFE produced a valid FO estimate
//  o_cfe_start       out  1            one-cycle CFE start pulse
//  o_timeout         out  1            one-cycle pulse: CFE did not answer in time
//  o_busy            out  1            high while in BUSY
//  o_wait_remaining  out  CFE_NBW_LAT  countdown value in COUNT, else 0
//  o_n_starts        out  CFE_NBW_CNT  number of start pulses issued, wraps
// BEHAVIOUR
//  Reset: state=IDLE; cnt, tmo and all outputs = 0. Async assertion clears everything immediately, mid-operation included.
//  All outputs are registered.
//  Wait value: Wload = (i_wait==0) ? 1 : i_wait, sampled at the load edge.
//  States:
//   IDLE
//     - If i_enable: cnt<=Wload, go COUNT.
//   COUNT
//     - If !i_enable: go IDLE, no start.
//     - Else if cnt==1: go BUSY, o_cfe_start<=1, o_n_starts<=o_n_starts+1, tmo<=0.
//     - Else cnt<=cnt-1.
//     - Result: COUNT lasts Wload cycles; o_cfe_start is high in the first BUSY cycle, exactly Wload edges after COUNT entry.
//   BUSY
//     - If i_cfe_valid (any BUSY cycle, including the first): go RELOAD if i_enable, else IDLE.
//     - Else if tmo==CFE_TIMEOUT-1: o_timeout<=1, go RELOAD if i_enable, else IDLE.
//     - Else tmo<=tmo+1.
//   RELOAD (1 cycle)
//     - If i_enable: cnt<=Wload, go COUNT.
//     - Else go IDLE.
//     - i_wait is sampled here, one cycle after i_cfe_valid, so the updated feedback wait is used.
//  Disable while BUSY does not abort the pending CFE run; the block waits for valid or timeout, then goes IDLE.
//  i_cfe_valid outside BUSY is ignored.
//  i_cfe_valid and timeout in the same cycle: valid wins, no o_timeout.
//  o_timeout is high only in the cycle after the timeout decision (RELOAD or IDLE).
//  o_n_starts wraps 2^CFE_NBW_CNT-1 -> 0 with no flag.
//  o_wait_remaining = cnt while in COUNT, else 0.
// TESTING
//  1. Nominal: i_wait=0x100; i_enable high from edge 0.
//     -> o_cfe_start high in cycle 256 only; o_busy=1 from 256; o_n_starts=1.
//  2. Reload uses new wait: after T1, i_cfe_valid at edge v, i_wait=0x200 from v+1.
//     -> next start at edge v+1+512; o_timeout stays 0.
//  3. Timeout: start issued, no valid, CFE_TIMEOUT=1024.
//     -> o_timeout one cycle at 1024 edges after BUSY entry; next start 1+Wload later.
//  4. Valid and timeout coincide: valid on the last tmo cycle.
//     -> no o_timeout, normal reload.
//  5. Disable: i_enable low mid-COUNT -> IDLE, no start.
//     Disable in BUSY then valid -> IDLE, no further start.
//  6. Edges:
//     - i_wait=0 -> start 1 edge after COUNT entry.
//     - o_n_starts=0xFFFF plus one start -> 0.
//     - rst_async mid-COUNT -> all outputs 0 immediately.

Source files
------------

// File: rtl/cfe_trigger_scheduler.sv
// CFE trigger scheduler: counts down the feedback wait, pulses the CFE start,
// then waits for the CFE answer (or a timeout) before reloading the next wait.
module cfe_trigger_scheduler #(
   parameter int unsigned CFE_NBW_LAT = 32,
   parameter int unsigned CFE_NBW_TMO = 16,
   parameter int unsigned CFE_TIMEOUT = 1024,
   parameter int unsigned CFE_NBW_CNT = 16
) (
   input  logic                   clk,
   input  logic                   rst_async,
   input  logic                   i_enable,
   input  logic [CFE_NBW_LAT-1:0] i_wait,
   input  logic                   i_cfe_valid,
   output logic                   o_cfe_start,
   output logic                   o_timeout,
   output logic                   o_busy,
   output logic [CFE_NBW_LAT-1:0] o_wait_remaining,
   output logic [CFE_NBW_CNT-1:0] o_n_starts
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_BUSY,
      S_RELOAD
   } state_t;

   localparam logic [CFE_NBW_LAT-1:0] LAT_ONE  = CFE_NBW_LAT'(1);
   localparam logic [CFE_NBW_TMO-1:0] TMO_ONE  = CFE_NBW_TMO'(1);
   localparam logic [CFE_NBW_TMO-1:0] TMO_LAST = CFE_NBW_TMO'(CFE_TIMEOUT - 1);
   localparam logic [CFE_NBW_CNT-1:0] CNT_ONE  = CFE_NBW_CNT'(1);

   state_t                 state;
   logic [CFE_NBW_LAT-1:0] cnt;
   logic [CFE_NBW_TMO-1:0] tmo;
   logic [CFE_NBW_LAT-1:0] wload;

   // A zero wait still needs one COUNT cycle so the start stays a clean pulse.
   assign wload = (i_wait == '0) ? LAT_ONE : i_wait;

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state            <= S_IDLE;
         cnt              <= '0;
         tmo              <= '0;
         o_cfe_start      <= 1'b0;
         o_timeout        <= 1'b0;
         o_busy           <= 1'b0;
         o_wait_remaining <= '0;
         o_n_starts       <= '0;
      end else begin
         // NOTE: defaults first; a later non-blocking assignment in the case overrides them.
         o_cfe_start      <= 1'b0;
         o_timeout        <= 1'b0;
         o_busy           <= 1'b0;
         o_wait_remaining <= '0;
         case (state)
            S_IDLE: begin
               if (i_enable) begin
                  cnt              <= wload;
                  o_wait_remaining <= wload;
                  state            <= S_COUNT;
               end
            end
            S_COUNT: begin
               if (!i_enable) begin
                  state <= S_IDLE;
               end else if (cnt == LAT_ONE) begin
                  state       <= S_BUSY;
                  o_busy      <= 1'b1;
                  o_cfe_start <= 1'b1;
                  o_n_starts  <= o_n_starts + CNT_ONE;
                  tmo         <= '0;
               end else begin
                  cnt              <= cnt - LAT_ONE;
                  o_wait_remaining <= cnt - LAT_ONE;
               end
            end
            S_BUSY: begin
               // A disable here does not abort the pending run; it only skips the reload.
               if (i_cfe_valid) begin
                  state <= i_enable ? S_RELOAD : S_IDLE;
               end else if (tmo == TMO_LAST) begin
                  o_timeout <= 1'b1;
                  state     <= i_enable ? S_RELOAD : S_IDLE;
               end else begin
                  tmo    <= tmo + TMO_ONE;
                  o_busy <= 1'b1;
               end
            end
            S_RELOAD: begin
               // The feedback stage has updated its wait on the valid edge, so sample it now.
               if (i_enable) begin
                  cnt              <= wload;
                  o_wait_remaining <= wload;
                  state            <= S_COUNT;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cfe_trigger_scheduler.sv
// Bench for cfe_trigger_scheduler: deadline-based reference model feeding a
// scoreboard that a negedge monitor drains against the DUT outputs.
module tb_cfe_trigger_scheduler;

   localparam int LAT     = 32;
   localparam int NBW_TMO = 16;
   localparam int TMO     = 40;
   localparam int NBW_CNT = 8;

   logic               clk       = 1'b0;
   logic               rst_async = 1'b0;
   logic               i_enable  = 1'b0;
   logic [LAT-1:0]     i_wait    = '0;
   logic               i_cfe_valid = 1'b0;
   logic               o_cfe_start;
   logic               o_timeout;
   logic               o_busy;
   logic [LAT-1:0]     o_wait_remaining;
   logic [NBW_CNT-1:0] o_n_starts;

   cfe_trigger_scheduler #(
      .CFE_NBW_LAT (LAT),
      .CFE_NBW_TMO (NBW_TMO),
      .CFE_TIMEOUT (TMO),
      .CFE_NBW_CNT (NBW_CNT)
   ) dut (
      .clk              (clk),
      .rst_async        (rst_async),
      .i_enable         (i_enable),
      .i_wait           (i_wait),
      .i_cfe_valid      (i_cfe_valid),
      .o_cfe_start      (o_cfe_start),
      .o_timeout        (o_timeout),
      .o_busy           (o_busy),
      .o_wait_remaining (o_wait_remaining),
      .o_n_starts       (o_n_starts)
   );

   always #5 clk = ~clk;

   // Index of the next rising edge while driving; last edge + 1 while monitoring.
   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Reference model: tracks absolute edge deadlines rather than counters.
   typedef enum {P_IDLE, P_COUNT, P_BUSY, P_RELOAD} phase_t;
   typedef struct {
      int busy;
      int rem;
      int start;
      int tmo;
      int n;
   } status_t;
   typedef struct {
      int is_start;
      int at;
   } event_t;

   phase_t  m_phase    = P_IDLE;
   int      m_deadline = 0;
   int      m_busy_from = 0;
   int      m_starts   = 0;
   status_t st_q[$];
   event_t  ev_q[$];

   task automatic model_step(input bit en, input int unsigned w, input bit v, input int k);
      int wl;
      int ev_s;
      int ev_t;
      status_t s;
      wl   = (w == 0) ? 1 : int'(w);
      ev_s = 0;
      ev_t = 0;
      case (m_phase)
         P_IDLE:
            if (en) begin
               m_phase    = P_COUNT;
               m_deadline = k + wl;
            end
         P_COUNT:
            if (!en) m_phase = P_IDLE;
            else if (k == m_deadline) begin
               m_phase     = P_BUSY;
               m_busy_from = k;
               m_starts++;
               ev_s = 1;
            end
         P_BUSY:
            if (v) m_phase = en ? P_RELOAD : P_IDLE;
            else if (k == m_busy_from + TMO) begin
               ev_t    = 1;
               m_phase = en ? P_RELOAD : P_IDLE;
            end
         P_RELOAD:
            if (en) begin
               m_phase    = P_COUNT;
               m_deadline = k + wl;
            end else m_phase = P_IDLE;
         default: m_phase = P_IDLE;
      endcase
      s.busy  = (m_phase == P_BUSY) ? 1 : 0;
      s.rem   = (m_phase == P_COUNT) ? (m_deadline - k) : 0;
      s.start = ev_s;
      s.tmo   = ev_t;
      s.n     = m_starts % (1 << NBW_CNT);
      st_q.push_back(s);
      if (ev_s != 0) ev_q.push_back('{1, k});
      if (ev_t != 0) ev_q.push_back('{0, k});
   endtask

   // Monitor: drains the scoreboard on the falling edge after each rising edge.
   status_t mon_s;
   event_t  mon_e;
   always @(negedge clk) begin
      if (!rst_async && st_q.size() > 0) begin
         mon_s = st_q.pop_front();
         check("busy", 32'(o_busy), mon_s.busy);
         check("wait_remaining", o_wait_remaining, mon_s.rem);
         check("start_pulse", 32'(o_cfe_start), mon_s.start);
         check("timeout_pulse", 32'(o_timeout), mon_s.tmo);
         check("n_starts", 32'(o_n_starts), mon_s.n);
      end
      if (!rst_async && (o_cfe_start || o_timeout)) begin
         if (ev_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: start=%0b timeout=%0b at edge %0d, none expected",
                     o_cfe_start, o_timeout, edge_cnt - 1);
         end else begin
            mon_e = ev_q.pop_front();
            check("event_kind_is_start", 32'(o_cfe_start), mon_e.is_start);
            check("event_edge", edge_cnt - 1, mon_e.at);
         end
      end
   end

   task automatic step(input bit en, input int unsigned w, input bit v);
      i_enable    = en;
      i_wait      = w;
      i_cfe_valid = v;
      model_step(en, w, v, edge_cnt);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic run_until_busy(input int unsigned w, input int limit);
      int i;
      i = 0;
      while (!o_busy && i < limit) begin
         step(1'b1, w, 1'b0);
         i++;
      end
      check("reach_busy", 32'(o_busy), 1);
   endtask

   task automatic do_reset(input string tag);
      rst_async   = 1'b1;
      i_enable    = 1'b0;
      i_cfe_valid = 1'b0;
      #1;
      check({tag, "_start"}, 32'(o_cfe_start), 0);
      check({tag, "_timeout"}, 32'(o_timeout), 0);
      check({tag, "_busy"}, 32'(o_busy), 0);
      check({tag, "_wait_remaining"}, o_wait_remaining, 0);
      check({tag, "_n_starts"}, 32'(o_n_starts), 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      st_q.delete();
      ev_q.delete();
      m_phase  = P_IDLE;
      m_starts = 0;
      rst_async = 1'b0;
   endtask

   initial begin
      #1;
      do_reset("reset");

      // Nominal: wait 0x100, start expected exactly 256 edges after COUNT entry.
      run_until_busy('h100, 300);
      repeat (5) step(1'b1, 'h100, 1'b0);
      // Valid, then the feedback stage publishes a new wait from the next cycle.
      step(1'b1, 'h100, 1'b1);
      run_until_busy('h200, 600);

      // Timeout: no valid for the whole window, then reload and restart.
      repeat (TMO + 2) step(1'b1, 7, 1'b0);
      run_until_busy(7, 50);

      // Valid on the very cycle the timeout would be decided.
      for (int i = 0; i < TMO && edge_cnt != m_busy_from + TMO; i++) step(1'b1, 5, 1'b0);
      step(1'b1, 5, 1'b1);

      // Disable mid-COUNT: back to IDLE with no start.
      repeat (10) step(1'b1, 50, 1'b0);
      repeat (8) step(1'b0, 50, 1'b0);

      // Disable in BUSY: the run completes on valid, then stays IDLE.
      run_until_busy(4, 20);
      repeat (3) step(1'b0, 4, 1'b0);
      step(1'b0, 4, 1'b1);
      repeat (6) step(1'b0, 4, 1'b0);

      // Zero wait and start-counter wrap: back-to-back runs answered immediately.
      for (int i = 0; i < 1000; i++) begin
         if (o_busy) step(1'b1, 0, 1'b1);
         else step(1'b1, 0, 1'b0);
      end

      // Randomized traffic; stray valids outside BUSY must be ignored.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 19) != 0), $urandom_range(0, 12), ($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset in the middle of a countdown.
      repeat (3) step(1'b0, 100, 1'b0);
      repeat (10) step(1'b1, 100, 1'b0);
      do_reset("reset_mid_count");
      repeat (20) step(1'b1, 3, 1'b0);

      check("leftover_events", ev_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
